// File: rtl/window_scan_ctrl.sv
// Raster sequencer for the 2R+1 line-buffer window generator: handshake, write strobe,
// window flag with centre coordinates, frame control. Optional WINDOW_SCAN_STALL_CNT_EN adds stall_cycles.
module window_scan_ctrl #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int R            = 2,
  parameter int CW           = $clog2(IMAGE_WIDTH),
  parameter int RW           = $clog2(IMAGE_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          buf_write,
  output logic [7:0]    buf_data,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          frame_busy,
  output logic          frame_done,
`ifdef WINDOW_SCAN_STALL_CNT_EN
  output logic [31:0]   stall_cycles,
`endif
  output logic [1:0]    dbg_state_o
);

  // Handshake: a pixel transfers on a rising edge where in_valid && in_ready are both high.
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(2 * R);
  localparam logic [RW-1:0] ROW_EDGE = RW'(2 * R);

  state_t        state_q;
  logic [CW-1:0] ci_q, ci_d;
  logic [RW-1:0] ri_q, ri_d;
  logic          in_ready_q, win_valid_q, frame_busy_q, frame_done_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;
  logic          accept, col_wrap, at_last, at_fill, in_win;

  always_comb begin
    // Reset gates the strobe so no write escapes in the cycle reset is applied.
    accept   = rst_n && in_valid && in_ready_q;
    col_wrap = (ci_q == COL_LAST);
    ci_d     = col_wrap ? '0 : ci_q + 1'b1;
    ri_d     = ri_q;
    if (col_wrap) ri_d = (ri_q == ROW_LAST) ? '0 : ri_q + 1'b1;
    at_last  = col_wrap && (ri_q == ROW_LAST);
    at_fill  = (ci_q == COL_EDGE) && (ri_q == ROW_EDGE);
    in_win   = (ci_q >= COL_EDGE) && (ri_q >= ROW_EDGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ci_q         <= '0;
      ri_q         <= '0;
      in_ready_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        ci_q <= ci_d;
        ri_q <= ri_d;
        if (in_win) begin
          win_valid_q <= 1'b1;
          win_row_q   <= ri_q - RW'(R);
          win_col_q   <= ci_q - CW'(R);
        end
      end
      case (state_q)
        IDLE: if (start) begin
          state_q      <= FILL;
          in_ready_q   <= 1'b1;
          frame_busy_q <= 1'b1;
          ci_q         <= '0;
          ri_q         <= '0;
        end
        FILL, RUN: if (accept && at_last) begin
          state_q      <= DONE;
          in_ready_q   <= 1'b0;
          frame_done_q <= 1'b1;
        end else if (accept && at_fill && state_q == FILL) begin
          state_q <= RUN;
        end
        DONE: begin
          state_q      <= IDLE;
          frame_busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WINDOW_SCAN_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else if (state_q == IDLE && start) stall_q <= '0;
    else if ((state_q == FILL || state_q == RUN) && !in_valid && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`endif

  assign in_ready    = in_ready_q;
  assign buf_write   = accept;
  assign buf_data    = accept ? in_data : 8'h00;
  assign win_valid   = win_valid_q;
  assign win_col     = win_col_q;
  assign win_row     = win_row_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Sequencing controller for the 2R+1 line-buffer window generator that feeds the Gaussian stage. It accepts a raster pixel stream through a valid/ready handshake and drives the line buffer's write strobe and data. It tracks input row/column and flags each cycle where the buffer holds a complete, border-free window, tagging it with the window-centre coordinates. It also frames the image with start/busy/done control.

## Interface

- IMAGE_WIDTH, 512, pixels per row (≥ 2R+1)
- IMAGE_HEIGHT, 512, rows per frame (≥ 2R+1)
- R, 2, window radius; must match the line buffer's R
- CW, $clog2(IMAGE_WIDTH), column counter width
- RW, $clog2(IMAGE_HEIGHT), row counter width

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; begins a frame when idle
- in_valid  in  1  upstream pixel valid
- in_data  in  8  upstream pixel
- in_ready  out  1  controller accepts pixel this cycle
- buf_write  out  1  line-buffer write strobe
- buf_data  out  8  line-buffer serial input
- win_valid  out  1  line buffer holds a full window this cycle
- win_col  out  CW  centre column of current window
- win_row  out  RW  centre row of current window
- frame_busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame

## Operation

- Accept occurs when in_valid && in_ready.
- buf_write = accept (combinational); buf_data = in_data. No write is issued without an accept.
- Counters ci (0..W-1) and ri (0..H-1) give the position of the next pixel to accept.
  - On accept, ci increments and wraps to 0 at W-1; on wrap, ri increments.
- FSM states:
  - IDLE: in_ready=0, frame_busy=0. start=1 → FILL; ci=ri=0.
  - FILL: in_ready=1, frame_busy=1. An accept at ri=2R, ci=2R → RUN.
  - RUN: in_ready=1, frame_busy=1. An accept at ri=H-1, ci=W-1 → DONE.
  - DONE: in_ready=0, frame_busy=1, frame_done=1 for exactly one cycle → IDLE.
- Window flag (registered): the cycle after an accept of pixel (ri, ci) with ri≥2R and ci≥2R:
  - win_valid=1
  - win_row=ri-R
  - win_col=ci-R
- Otherwise win_valid=0; win_row and win_col hold their last values.
- Windows per frame: exactly (H-2R)·(W-2R), in raster order. Row-wrap positions (ci<2R) never flag.
- start outside IDLE is ignored. start while rst_n=0 is ignored; reset wins.
- Reset mid-frame: the FSM returns to IDLE and the counters clear. Stale line-buffer contents never flag, because the next frame refills from (0,0).

## Timing

- Reset values: in_ready=0, buf_write=0, buf_data=0, win_valid=0, win_col=0, win_row=0, frame_busy=0, frame_done=0; stall_cycles=0 when configured.
- start sampled in cycle t → in_ready=1 in t+1.
- Write latency is 0 cycles (buf_write in the accept cycle). Window-flag latency is 1 cycle after the accept.
- The final accept is at cycle t. In t+1: the last win_valid (row H-1-R, col W-1-R), frame_done=1 and in_ready=0. In t+2: the FSM is in IDLE.
- Back-to-back frames are possible: start in the DONE cycle is ignored, so the earliest accepted start is at t+2.
- Input bubbles (in_valid=0) freeze the counters and produce no write or flag. Throughput is 1 pixel/cycle.

## Configuration

- WINDOW_SCAN_STALL_CNT_EN defined: adds the output port stall_cycles (out, 32 bits).
  - Counts cycles in FILL or RUN with in_valid=0.
  - Clears on start acceptance and on reset; saturates at 2^32-1.
  - Holds its value in IDLE and DONE.
- Undefined: no port and no counter logic; all other behaviour is identical.

## Test plan

Bench parameters: W=8, H=6, R=1.

- Reset: hold rst_n=0 for 3 cycles with in_valid=1 and start=1 → every output is 0 and no buf_write.
- Continuous frame: start, then in_valid=1 for 48 accepts. Required response:
  - 48 buf_write pulses.
  - 24 win_valid pulses; the first is (row 1, col 1), one cycle after the 19th accept.
  - frame_done is coincident with window (4, 6), one cycle after the 48th accept, with in_ready=0 in that cycle.
- Bubbles: in_valid alternating 1/0 → the same 24 windows in the same order; win_valid is never high in the cycle after a non-accept cycle.
- Row edges: in rows 2..5, the accepts at ci=0 and ci=1 produce no win_valid; the accept at ci=2 produces (ri-1, 1).
- Reset mid-frame after 30 accepts → all outputs 0 on the next cycle. A new start followed by a full frame yields exactly 24 windows starting at (1, 1).
- start pulsed during RUN is ignored. With WINDOW_SCAN_STALL_CNT_EN defined, 10 bubble cycles within a frame → stall_cycles=10 at frame_done.
